// File: rtl/imm_pkg.sv
// Shared opcode map, format indices and format type for the decode-stage
// immediate generator.
package imm_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;

    typedef logic [5:0] fmt_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational opcode classifier and immediate extractor; the immediate is
// built as a sign-correct 32-bit value, then sign-extended to XLEN.
module imm_gen
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output fmt_t            format,
    output logic [XLEN-1:0] immediate,
    output logic            unknown
);

    logic [31:0] imm32_s;

    // Opcode to one-hot format plus the matching immediate bit shuffle
    always_comb begin
        format  = 6'b000000;
        imm32_s = 32'd0;
        unknown = 1'b0;
        case (inst[6:0])
            OP_R: begin
                format[FMT_R] = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
                format[FMT_I] = 1'b1;
                imm32_s = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                format[FMT_S] = 1'b1;
                imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                format[FMT_B] = 1'b1;
                imm32_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                format[FMT_U] = 1'b1;
                imm32_s = {inst[31:12], 12'h000};
            end
            OP_JAL: begin
                format[FMT_J] = 1'b1;
                imm32_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                unknown = 1'b1;
            end
        endcase
    end

    // Bit 31 of every 32-bit form is already inst[31] (or 0 for R/unknown)
    assign immediate = XLEN'($signed(imm32_s));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode-stage front end: classifies the incoming instruction and
// presents format/immediate one cycle later behind a skid-buffered handshake.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int EN_ILLEGAL = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_pc,
    output fmt_t            o_format,
    output logic [XLEN-1:0] o_immediate,
    output logic            o_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    fmt_t            format_s;
    logic [XLEN-1:0] immediate_s;
    logic            unknown_s;
    logic            illegal_s;
    logic            accept_s;
    logic            out_load_s;

    logic            skid_valid_r;
    logic [31:0]     skid_inst_r;
    logic [XLEN-1:0] skid_pc_r;
    fmt_t            skid_format_r;
    logic [XLEN-1:0] skid_imm_r;
    logic            skid_illegal_r;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst      (i_inst),
        .format    (format_s),
        .immediate (immediate_s),
        .unknown   (unknown_s)
    );

    assign illegal_s  = (EN_ILLEGAL != 0) ? unknown_s : 1'b0;
    assign o_ready    = ~skid_valid_r;
    assign accept_s   = i_valid & o_ready;
    assign out_load_s = ~o_valid | i_ready;

    // Output register and skid entry; skid drains first to keep FIFO order
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid        <= 1'b0;
            o_inst         <= 32'd0;
            o_pc           <= '0;
            o_format       <= 6'b000000;
            o_immediate    <= '0;
            o_illegal      <= 1'b0;
            skid_valid_r   <= 1'b0;
            skid_inst_r    <= 32'd0;
            skid_pc_r      <= '0;
            skid_format_r  <= 6'b000000;
            skid_imm_r     <= '0;
            skid_illegal_r <= 1'b0;
        end else if (i_flush) begin
            o_valid      <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (out_load_s) begin
            if (skid_valid_r) begin
                o_valid      <= 1'b1;
                o_inst       <= skid_inst_r;
                o_pc         <= skid_pc_r;
                o_format     <= skid_format_r;
                o_immediate  <= skid_imm_r;
                o_illegal    <= skid_illegal_r;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                o_valid     <= 1'b1;
                o_inst      <= i_inst;
                o_pc        <= i_pc;
                o_format    <= format_s;
                o_immediate <= immediate_s;
                o_illegal   <= illegal_s;
            end else begin
                o_valid <= 1'b0;
            end
        end else if (accept_s) begin
            // Output is stalled, so the new entry parks in the skid slot
            skid_valid_r   <= 1'b1;
            skid_inst_r    <= i_inst;
            skid_pc_r      <= i_pc;
            skid_format_r  <= format_s;
            skid_imm_r     <= immediate_s;
            skid_illegal_r <= illegal_s;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

endmodule
